// File: rtl/cmd_frame_dispatch_if.sv
// ---------------------------------------------------------------------------
// cmd_frame_dispatch_if
//   Groups the byte-stream and channel-bus signals of cmd_frame_dispatch.
//   Signal names keep the historic USB-JTAG decoder port names so that the
//   surrounding peripheral controllers can be wired up unchanged.
//
//   RXD side  : iRXD_DATA, iRXD_Ready          (byte in, 1-cycle strobe)
//   TXD side  : oTXD_DATA, oTXD_Start, iTXD_Done (byte out, start/done)
//   Channels  : oCH_Req / iCH_Ack (one-hot req, per-channel ack pulse),
//               oCH_Action, oCH_ADDR, oCH_DATA, oCH_MODE (frame fields),
//               iCH_RDATA (16 bits per channel, channel k at [16k+15:16k])
//
//   master : the dispatcher
//   slave  : the byte interface and channel environment
// ---------------------------------------------------------------------------
interface cmd_frame_dispatch_if #(
    parameter int NUM_CH = 4
);
    logic [7:0]           iRXD_DATA;
    logic                 iRXD_Ready;
    logic [7:0]           oTXD_DATA;
    logic                 oTXD_Start;
    logic                 iTXD_Done;
    logic [NUM_CH-1:0]    oCH_Req;
    logic [NUM_CH-1:0]    iCH_Ack;
    logic [7:0]           oCH_Action;
    logic [23:0]          oCH_ADDR;
    logic [15:0]          oCH_DATA;
    logic [7:0]           oCH_MODE;
    logic [16*NUM_CH-1:0] iCH_RDATA;

    modport master (
        input  iRXD_DATA, iRXD_Ready, iTXD_Done, iCH_Ack, iCH_RDATA,
        output oTXD_DATA, oTXD_Start, oCH_Req, oCH_Action, oCH_ADDR,
               oCH_DATA, oCH_MODE
    );

    modport slave (
        output iRXD_DATA, iRXD_Ready, iTXD_Done, iCH_Ack, iCH_RDATA,
        input  oTXD_DATA, oTXD_Start, oCH_Req, oCH_Action, oCH_ADDR,
               oCH_DATA, oCH_MODE
    );
endinterface

// File: rtl/cmd_frame_dispatch.sv
// ---------------------------------------------------------------------------
// cmd_frame_dispatch
//   Assembles 8-byte command frames (ACTION, TARGET, ADDR[23:16], ADDR[15:8],
//   ADDR[7:0], DATA[15:8], DATA[7:0], MODE) from the RXD byte stream, decodes
//   the TARGET byte into one of NUM_CH channels, runs a req/ack handshake with
//   that channel and, for reads, returns RSP_BYTES bytes of read data (LSB
//   first) on the TXD interface.
//
// Ports
//   iCLK      : system clock
//   iRST_n    : asynchronous active-low reset
//   bus       : cmd_frame_dispatch_if.master (RXD, TXD and channel bus)
//   oErr_Cnt  : saturating error counter (at most +1 per cycle)
//   oBusy     : high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module cmd_frame_dispatch #(
    parameter int         NUM_CH      = 4,
    parameter logic [7:0] TGT_BASE    = 8'h10,
    parameter int         RSP_BYTES   = 2,
    parameter int         TIMEOUT_CYC = 50000,
    parameter logic [7:0] ACT_WR      = 8'h83,
    parameter logic [7:0] ACT_RD      = 8'h94
) (
    input  logic                        iCLK,
    input  logic                        iRST_n,
    cmd_frame_dispatch_if.master        bus,
    output logic [7:0]                  oErr_Cnt,
    output logic                        oBusy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_REQ    = 2'd2;
    localparam logic [1:0] ST_TX     = 2'd3;

    // One timer serves both the inter-byte gap (IDLE) and the ack wait (REQ);
    // the two are never active at the same time.
    localparam int          TW       = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [1:0]        state_q,     state_d;
    logic [2:0]        cnt_q,       cnt_d;
    logic [7:0]        frame_q [8];
    logic [7:0]        frame_d [8];
    logic [TW-1:0]     timer_q,     timer_d;
    logic [7:0]        err_q,       err_d;
    logic [2:0]        ch_q,        ch_d;
    logic [NUM_CH-1:0] req_q,       req_d;
    logic [7:0]        act_q,       act_d;
    logic [23:0]       addr_q,      addr_d;
    logic [15:0]       data_q,      data_d;
    logic [7:0]        mode_q,      mode_d;
    logic [15:0]       rsp_q,       rsp_d;
    logic              tx_idx_q,    tx_idx_d;
    logic              tx_start_q,  tx_start_d;
    logic [7:0]        txd_data_q,  txd_data_d;

    logic              err_inc;
    logic              ack_sel;
    logic [15:0]       rdata_sel;
    logic [7:0]        tgt_off;
    logic              decode_bad;

    // Channel offset of the buffered TARGET byte; an underflow is caught
    // separately by the TARGET < TGT_BASE test.
    assign tgt_off = frame_q[1] - TGT_BASE;

    assign decode_bad = (frame_q[1] < TGT_BASE) ||
                        (int'(tgt_off) >= NUM_CH) ||
                        ((frame_q[0] != ACT_WR) && (frame_q[0] != ACT_RD));

    // Pick out the ack bit and read-data slice of the latched channel.
    always_comb begin
        ack_sel   = 1'b0;
        rdata_sel = 16'h0000;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == 3'(k)) begin
                ack_sel   = bus.iCH_Ack[k];
                rdata_sel = bus.iCH_RDATA[16*k +: 16];
            end
        end
    end

    // Next-state logic for the frame assembler, dispatcher FSM and TX sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frame_d    = frame_q;
        timer_d    = timer_q;
        ch_d       = ch_q;
        req_d      = req_q;
        act_d      = act_q;
        addr_d     = addr_q;
        data_d     = data_q;
        mode_d     = mode_q;
        rsp_d      = rsp_q;
        tx_idx_d   = tx_idx_q;
        tx_start_d = tx_start_q;
        txd_data_d = txd_data_q;
        err_inc    = 1'b0;

        // Bytes arriving while a frame is being processed are discarded.
        if (bus.iRXD_Ready && (state_q != ST_IDLE)) begin
            err_inc = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.iRXD_Ready) begin
                    frame_d[cnt_q] = bus.iRXD_DATA;
                    cnt_d          = cnt_q + 3'd1;
                    timer_d        = '0;
                    if (cnt_q == 3'd7) begin
                        state_d = ST_DECODE;
                    end
                end else if (cnt_q != 3'd0) begin
                    // A byte arriving on the last allowed cycle still counts.
                    if (timer_q == TMO_LAST) begin
                        cnt_d   = 3'd0;
                        timer_d = '0;
                        err_inc = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end

            ST_DECODE: begin
                timer_d = '0;
                if (decode_bad) begin
                    err_inc = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    act_d  = frame_q[0];
                    addr_d = {frame_q[2], frame_q[3], frame_q[4]};
                    data_d = {frame_q[5], frame_q[6]};
                    mode_d = frame_q[7];
                    ch_d   = tgt_off[2:0];
                    for (int k = 0; k < NUM_CH; k++) begin
                        req_d[k] = (tgt_off == 8'(k));
                    end
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                // The ack is tested first so that it wins over a timeout
                // expiring in the same cycle.
                if (ack_sel) begin
                    req_d   = '0;
                    timer_d = '0;
                    if (act_q == ACT_RD) begin
                        rsp_d      = rdata_sel;
                        tx_idx_d   = 1'b0;
                        txd_data_d = rdata_sel[7:0];
                        tx_start_d = 1'b1;
                        state_d    = ST_TX;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (timer_q == TMO_LAST) begin
                    req_d   = '0;
                    timer_d = '0;
                    err_inc = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            ST_TX: begin
                // Start is held until Done, then low for exactly one cycle
                // before the next byte is presented.
                if (tx_start_q) begin
                    if (bus.iTXD_Done) begin
                        tx_start_d = 1'b0;
                        if (int'(tx_idx_q) == RSP_BYTES - 1) begin
                            state_d = ST_IDLE;
                        end else begin
                            tx_idx_d = tx_idx_q + 1'b1;
                        end
                    end
                end else begin
                    tx_start_d = 1'b1;
                    txd_data_d = tx_idx_q ? rsp_q[15:8] : rsp_q[7:0];
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        err_d = (err_inc && (err_q != 8'hFF)) ? (err_q + 8'd1) : err_q;
    end

    // State registers; everything returns to zero as soon as reset asserts.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            frame_q    <= '{default: 8'h00};
            timer_q    <= '0;
            err_q      <= 8'h00;
            ch_q       <= 3'd0;
            req_q      <= '0;
            act_q      <= 8'h00;
            addr_q     <= 24'h000000;
            data_q     <= 16'h0000;
            mode_q     <= 8'h00;
            rsp_q      <= 16'h0000;
            tx_idx_q   <= 1'b0;
            tx_start_q <= 1'b0;
            txd_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
            ch_q       <= ch_d;
            req_q      <= req_d;
            act_q      <= act_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            mode_q     <= mode_d;
            rsp_q      <= rsp_d;
            tx_idx_q   <= tx_idx_d;
            tx_start_q <= tx_start_d;
            txd_data_q <= txd_data_d;
        end
    end

    assign bus.oCH_Req    = req_q;
    assign bus.oCH_Action = act_q;
    assign bus.oCH_ADDR   = addr_q;
    assign bus.oCH_DATA   = data_q;
    assign bus.oCH_MODE   = mode_q;
    assign bus.oTXD_DATA  = txd_data_q;
    assign bus.oTXD_Start = tx_start_q;
    assign oErr_Cnt       = err_q;
    assign oBusy          = (state_q != ST_IDLE);

endmodule
